// File: rtl/soc_timer_pkg.sv
// soc_timer_pkg: shared definitions for the soc_timer peripheral.
//   - register byte offsets
//   - CTRL bit positions and the packed CTRL struct
//   - byte-enable merge helper used by every writable register
package soc_timer_pkg;

    localparam logic [31:0] TIMER_CTRL   = 32'h00;
    localparam logic [31:0] TIMER_PRESC  = 32'h04;
    localparam logic [31:0] TIMER_CNT    = 32'h08;
    localparam logic [31:0] TIMER_CMP    = 32'h0C;
    localparam logic [31:0] TIMER_STATUS = 32'h10;

    localparam int CTRL_EN         = 0;
    localparam int CTRL_AUTORELOAD = 1;
    localparam int CTRL_IRQ_EN     = 2;

    // Declared MSB first so that en lands on bit CTRL_EN.
    typedef struct packed {
        logic irq_en;
        logic autoreload;
        logic en;
    } timer_ctrl_t;

    // Replace only the bytes selected by be.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++)
            if (be[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/soc_timer_prescaler.sv
// soc_timer_prescaler: divides the clock by presc+1 and emits a one-cycle tick.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   en            effective enable; low forces the counter to 0, no tick
//   presc         terminal count (tick every presc+1 clocks)
//   presc_wr      presc is being rewritten: restart from 0 and drop this tick
//   tick          one-cycle pulse when the counter wraps
module soc_timer_prescaler #(
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] presc,
    input  logic                   presc_wr,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] cnt_q, cnt_d;
    logic                   wrap;

    assign wrap = (cnt_q == presc);
    assign tick = en && !presc_wr && wrap;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!en || presc_wr || wrap) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/soc_timer.sv
// soc_timer: memory-mapped 32-bit timer/compare peripheral.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   req/gnt             request, combinational grant (no wait states)
//   we, be, addr, wdata write enable, byte enables, byte address, write data
//   rvalid, rdata, err  registered response, one cycle after the request
//   irq                 level interrupt = MATCH & IRQ_EN
module soc_timer
    import soc_timer_pkg::*;
#(
    parameter int PRESC_WIDTH  = 16,
    parameter int OFFSET_WIDTH = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    output logic        gnt,
    output logic        rvalid,
    input  logic        we,
    input  logic [3:0]  be,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        err,
    output logic        irq
);

    timer_ctrl_t            ctrl_q, ctrl_d;
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic [31:0]            cnt_q, cnt_d;
    logic [31:0]            cmp_q, cmp_d;
    logic                   match_q, match_d;
    logic                   rvalid_q, err_q, err_d;
    logic [31:0]            rdata_q, rdata_d;

    logic [31:0] off, presc_ext, presc_new;
    logic        hit_ctrl, hit_presc, hit_cnt, hit_cmp, hit_status;
    logic        valid, wr, rd, presc_wr, en_eff, tick, match_set;

    logic unused_addr;
    assign unused_addr = ^addr[31:OFFSET_WIDTH];

    assign gnt = req;

    // Address decode
    always_comb begin
        off = '0;
        off[OFFSET_WIDTH-1:0] = addr[OFFSET_WIDTH-1:0];
        presc_ext = '0;
        presc_ext[PRESC_WIDTH-1:0] = presc_q;
    end

    assign hit_ctrl   = (off == TIMER_CTRL);
    assign hit_presc  = (off == TIMER_PRESC);
    assign hit_cnt    = (off == TIMER_CNT);
    assign hit_cmp    = (off == TIMER_CMP);
    assign hit_status = (off == TIMER_STATUS);
    assign valid = (addr[1:0] == 2'b00) &&
                   (hit_ctrl || hit_presc || hit_cnt || hit_cmp || hit_status);
    assign wr       = req && we && valid;
    assign rd       = req && !we && valid;
    assign presc_wr = wr && hit_presc;

    // Disabling through a CTRL write stops the prescaler this very cycle;
    // enabling only takes effect from the next cycle.
    assign en_eff = ctrl_q.en && ctrl_d.en;

    soc_timer_prescaler #(.PRESC_WIDTH(PRESC_WIDTH)) u_presc (
        .clk      (clk),
        .rst      (rst),
        .en       (en_eff),
        .presc    (presc_q),
        .presc_wr (presc_wr),
        .tick     (tick)
    );

    // Compare always uses the pre-write CNT/CMP values.
    assign match_set = tick && (cnt_q == cmp_q);

    always_comb begin
        ctrl_d    = ctrl_q;
        presc_d   = presc_q;
        cnt_d     = cnt_q;
        cmp_d     = cmp_q;
        presc_new = be_merge(presc_ext, wdata, be);

        if (wr && hit_ctrl && be[0]) ctrl_d = timer_ctrl_t'(wdata[2:0]);
        if (presc_wr)                presc_d = presc_new[PRESC_WIDTH-1:0];
        if (wr && hit_cmp)           cmp_d = be_merge(cmp_q, wdata, be);

        if (tick) cnt_d = (match_set && ctrl_q.autoreload) ? 32'h0 : cnt_q + 32'h1;
        // A bus write wins over the tick update.
        if (wr && hit_cnt) cnt_d = be_merge(cnt_q, wdata, be);

        // A new match wins over a W1C in the same cycle.
        match_d = match_set ||
                  (match_q && !(wr && hit_status && be[0] && wdata[0]));
    end

    // Response path
    always_comb begin
        rdata_d = '0;
        err_d   = req && !valid;
        if (rd) begin
            if (hit_ctrl)   rdata_d = {29'h0, ctrl_q};
            if (hit_presc)  rdata_d = presc_ext;
            if (hit_cnt)    rdata_d = cnt_q;
            if (hit_cmp)    rdata_d = cmp_q;
            if (hit_status) rdata_d = {31'h0, match_q};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q   <= '0;
            presc_q  <= '0;
            cnt_q    <= '0;
            cmp_q    <= '0;
            match_q  <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            cnt_q    <= cnt_d;
            cmp_q    <= cmp_d;
            match_q  <= match_d;
            rvalid_q <= req;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign err    = err_q;
    assign irq    = match_q && ctrl_q.irq_en;

endmodule

// File: tb/tb_soc_timer.sv
// tb_soc_timer: directed plus randomized bus traffic against a cycle-level
// behavioural model of the timer written from the register-map rules.
module tb_soc_timer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0, we = 1'b0;
    logic [3:0]  be = 4'h0;
    logic [31:0] addr = '0, wdata = '0;
    logic        gnt, rvalid, err, irq;
    logic [31:0] rdata;

    int n_chk = 0, n_err = 0;

    soc_timer dut (
        .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rvalid(rvalid),
        .we(we), .be(be), .addr(addr), .wdata(wdata), .rdata(rdata),
        .err(err), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit          m_en, m_ar, m_ie, m_match;
    int unsigned m_presc, m_pc;
    logic [31:0] m_cnt, m_cmp;
    bit          e_rvalid, e_err;
    logic [31:0] e_rdata;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] b);
        logic [31:0] mask;
        mask = {{8{b[3]}}, {8{b[2]}}, {8{b[1]}}, {8{b[0]}}};
        return (o & ~mask) | (n & mask);
    endfunction

    task automatic model_reset();
        m_en = 0; m_ar = 0; m_ie = 0; m_match = 0;
        m_presc = 0; m_pc = 0; m_cnt = 0; m_cmp = 0;
        e_rvalid = 0; e_err = 0; e_rdata = 0;
    endtask

    task automatic model(input bit r, input bit w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        int unsigned off;
        bit valid, wrt, tick, pw, en_now, hit;
        logic [31:0] rv, old_cnt;
        off   = a[4:0];
        valid = (a[1:0] == 0) && (off <= 16);
        case (off)
            0:  rv = {29'h0, m_ie, m_ar, m_en};
            4:  rv = m_presc;
            8:  rv = m_cnt;
            12: rv = m_cmp;
            16: rv = {31'h0, m_match};
            default: rv = 0;
        endcase
        e_rvalid = r;
        e_err    = r && !valid;
        e_rdata  = (r && !w && valid) ? rv : 32'h0;
        wrt    = r && w && valid;
        pw     = wrt && off == 4;
        en_now = m_en && !(wrt && off == 0 && b[0] && !d[0]);
        tick   = 0;
        if (!en_now || pw) m_pc = 0;
        else if (m_pc == m_presc) begin tick = 1; m_pc = 0; end
        else m_pc++;
        old_cnt = m_cnt;
        hit = tick && (old_cnt == m_cmp);
        if (tick) m_cnt = (hit && m_ar) ? 32'h0 : old_cnt + 1;
        if (hit) m_match = 1;
        else if (wrt && off == 16 && b[0] && d[0]) m_match = 0;
        if (wrt) begin
            if (off == 0 && b[0]) begin m_en = d[0]; m_ar = d[1]; m_ie = d[2]; end
            if (off == 4)  m_presc = merge(m_presc, d, b) & 32'hFFFF;
            if (off == 8)  m_cnt = merge(old_cnt, d, b);
            if (off == 12) m_cmp = merge(m_cmp, d, b);
        end
    endtask

    // One bus cycle: drive, clock, update model, compare.
    task automatic step(input bit r, input bit w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d);
        req = r; we = w; be = b; addr = a; wdata = d;
        #0;
        chk("gnt", gnt, r);
        @(posedge clk);
        model(r, w, b, a, d);
        #1;
        chk("rvalid", rvalid, e_rvalid);
        if (e_rvalid) begin
            chk("rdata", rdata, e_rdata);
            chk("err", err, e_err);
        end
        chk("irq", irq, m_match && m_ie);
        req = 0; we = 0;
    endtask

    task automatic wr32(input logic [31:0] a, input logic [31:0] d);
        step(1, 1, 4'hF, a, d);
    endtask
    task automatic rd_exp(input string tag, input logic [31:0] a, input logic [31:0] exp);
        step(1, 0, 4'hF, a, 0);
        chk(tag, rdata, exp);
    endtask
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
    endtask
    task automatic do_reset(input bit with_req);
        rst = 1; req = with_req; we = 0; addr = 0;
        @(posedge clk);
        model_reset();
        #1;
        chk("rst_rvalid", rvalid, 0);
        chk("rst_irq", irq, 0);
        rst = 0; req = 0;
    endtask

    initial begin
        logic [31:0] ra;
        model_reset();
        do_reset(0);

        // 1. reset values
        for (int i = 0; i < 5; i++) rd_exp("reset_reg", i * 4, 0);
        rd_exp("unmapped_rdata", 32'h14, 0);
        chk("unmapped_err", err, 1);

        // 2. basic match with autoreload
        wr32(32'h04, 0);
        wr32(32'h0C, 5);
        wr32(32'h00, 7);
        for (int i = 0; i < 50 && !irq; i++) idle(1);
        chk("irq_rise", irq, 1);
        wr32(32'h10, 1);
        idle(3);

        // 3. prescaled free-run and wrap
        do_reset(0);
        wr32(32'h04, 3);
        wr32(32'h0C, 2);
        wr32(32'h00, 5);
        idle(20);
        rd_exp("cnt_after_match", 32'h08, m_cnt);
        wr32(32'h00, 0);
        wr32(32'h08, 32'hFFFF_FFFF);
        wr32(32'h0C, 0);
        wr32(32'h10, 1);
        wr32(32'h00, 5);
        idle(12);
        chk("wrap_match", irq, 1);

        // 4. coincident events, tick every clock
        do_reset(0);
        wr32(32'h00, 1);
        idle(2);
        wr32(32'h08, 100);
        rd_exp("cnt_write_wins", 32'h08, 100);
        wr32(32'h00, 0);
        wr32(32'h08, 0);
        wr32(32'h0C, 0);
        wr32(32'h00, 3);           // match on every tick
        idle(2);
        wr32(32'h10, 1);
        rd_exp("match_beats_w1c", 32'h10, 1);

        // 5. byte enables and misaligned access
        wr32(32'h00, 0);
        wr32(32'h0C, 0);
        step(1, 1, 4'b0101, 32'h0C, 32'hAABB_CCDD);
        rd_exp("be_merge", 32'h0C, 32'h00BB_00DD);
        step(1, 1, 4'hF, 32'h02, 32'h1234_5678);
        chk("misaligned_err", err, 1);
        rd_exp("misaligned_nochange", 32'h0C, 32'h00BB_00DD);

        // 6. back-to-back, then reset with a request pending
        wr32(32'h04, 9);
        rd_exp("b2b_0", 32'h04, 9);
        rd_exp("b2b_1", 32'h0C, 32'h00BB_00DD);
        rd_exp("b2b_2", 32'h00, 0);
        req = 1;
        do_reset(1);
        for (int i = 0; i < 5; i++) rd_exp("post_rst_reg", i * 4, 0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 1) == 0) begin
                idle(1);
            end else begin
                ra = $urandom_range(0, 7) * 4;
                if ($urandom_range(0, 15) == 0) ra = ra | 32'($urandom_range(1, 3));
                case (ra)
                    0:  step(1, $urandom_range(0, 3) != 0, 4'($urandom), ra, 32'($urandom_range(0, 7)) | 1);
                    4:  step(1, $urandom_range(0, 3) == 0, 4'($urandom), ra, 32'($urandom_range(0, 3)));
                    8:  step(1, $urandom_range(0, 3) == 0, 4'($urandom), ra, 32'($urandom_range(0, 15)));
                    12: step(1, $urandom_range(0, 1) == 0, 4'($urandom), ra, 32'($urandom_range(0, 15)));
                    default: step(1, $urandom_range(0, 1) == 0, 4'($urandom), ra, $urandom);
                endcase
            end
            if ($urandom_range(0, 999) == 0) do_reset($urandom_range(0, 1) == 1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
